// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
//
// Synchronous driver for an external active-low cross-coupled NAND SR latch.
// A single-cycle set or clear request starts a fixed-width low pulse on
// set_n or reset_n. The two drives are never low together. The latch's q/qbar
// feedback then passes through a two-flop synchronizer. The block reports
// done when the feedback confirms the commanded state, or err if the
// confirmation does not arrive within TIMEOUT cycles.
//
// Parameters
//   PULSE_W   width of the low drive pulse in clock cycles (>= 1)
//   TIMEOUT   maximum number of WAIT cycles before err is flagged (>= 1)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req_set    in   request to set the latch (sampled only in IDLE)
//   req_reset  in   request to clear the latch (sampled only in IDLE)
//   set_n      out  registered active-low set drive
//   reset_n    out  registered active-low reset drive
//   q          in   latch true output (asynchronous)
//   qbar       in   latch complement output (asynchronous)
//   busy       out  high while a command is in PULSE or WAIT
//   done       out  one-cycle pulse: latch confirmed the commanded state
//   err        out  one-cycle pulse: both requests at once, or timeout
//   state_q    out  last confirmed latch state (1 = set)
// -----------------------------------------------------------------------------
module sr_latch_driver #(
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic req_set,
  input  logic req_reset,
  output logic set_n,
  output logic reset_n,
  input  logic q,
  input  logic qbar,
  output logic busy,
  output logic done,
  output logic err,
  output logic state_q
);

  localparam int PCW = $clog2(PULSE_W + 1);
  localparam int WCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_cmd;
  logic [PCW-1:0]   r_pulse_cnt;
  logic [WCW-1:0]   r_wait_cnt;
  logic             r_set_n;
  logic             r_reset_n;
  logic             r_done;
  logic             r_err;
  logic             r_state_q;
  logic             r_q_meta;
  logic             r_q_s;
  logic             r_qbar_meta;
  logic             r_qbar_s;

  state_t           w_state_nxt;
  logic             w_cmd_nxt;
  logic [PCW-1:0]   w_pulse_cnt_nxt;
  logic [WCW-1:0]   w_wait_cnt_nxt;
  logic             w_set_n_nxt;
  logic             w_reset_n_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_state_q_nxt;
  logic             w_match;

  // The forbidden feedback (q_s == qbar_s) can never satisfy both terms.
  assign w_match = (r_q_s == r_cmd) && (r_qbar_s == ~r_cmd);

  // NOTE: combinational logic uses blocking assignments. Every output gets a
  // default first so that no path leaves a value unassigned, which would
  // infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_nxt       = r_cmd;
    w_pulse_cnt_nxt = r_pulse_cnt;
    w_wait_cnt_nxt  = r_wait_cnt;
    w_set_n_nxt     = 1'b1;
    w_reset_n_nxt   = 1'b1;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    w_state_q_nxt   = r_state_q;

    case (r_state)
      ST_IDLE: begin
        if (req_set && req_reset) begin
          w_err_nxt = 1'b1;
        end else if (req_set || req_reset) begin
          w_cmd_nxt       = req_set;
          w_state_nxt     = ST_PULSE;
          w_pulse_cnt_nxt = '0;
          w_set_n_nxt     = ~req_set;
          w_reset_n_nxt   = req_set;
        end
      end

      ST_PULSE: begin
        if (r_pulse_cnt == PCW'(PULSE_W - 1)) begin
          // The last pulse cycle: both drives go high on this edge.
          w_state_nxt    = ST_WAIT;
          w_wait_cnt_nxt = WCW'(1);
        end else begin
          w_pulse_cnt_nxt = r_pulse_cnt + PCW'(1);
          w_set_n_nxt     = ~r_cmd;
          w_reset_n_nxt   = r_cmd;
        end
      end

      ST_WAIT: begin
        // A match wins over a timeout that lands in the same cycle.
        if (w_match) begin
          w_done_nxt    = 1'b1;
          w_state_q_nxt = r_cmd;
          w_state_nxt   = ST_IDLE;
        end else if (r_wait_cnt == WCW'(TIMEOUT)) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments. All flops,
  // including the synchronizer, take the reset value so an aborted command
  // leaves no stale feedback behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cmd       <= 1'b0;
      r_pulse_cnt <= '0;
      r_wait_cnt  <= '0;
      r_set_n     <= 1'b1;
      r_reset_n   <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_state_q   <= 1'b0;
      r_q_meta    <= 1'b0;
      r_q_s       <= 1'b0;
      r_qbar_meta <= 1'b0;
      r_qbar_s    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_pulse_cnt <= w_pulse_cnt_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_set_n     <= w_set_n_nxt;
      r_reset_n   <= w_reset_n_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_state_q   <= w_state_q_nxt;
      r_q_meta    <= q;
      r_q_s       <= r_q_meta;
      r_qbar_meta <= qbar;
      r_qbar_s    <= r_qbar_meta;
    end
  end

  assign set_n   = r_set_n;
  assign reset_n = r_reset_n;
  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign err     = r_err;
  assign state_q = r_state_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_driver
//
// Directed bench for sr_latch_driver with the default parameters (PULSE_W=2,
// TIMEOUT=15). A behavioural NAND-latch model closes the q/qbar loop. It can
// be forced stuck at q=0 to provoke a timeout. Inputs change 1 ns after a
// rising edge, and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic reset;
  logic req_set;
  logic req_reset;
  logic set_n;
  logic reset_n;
  logic q;
  logic qbar;
  logic busy;
  logic done;
  logic err;
  logic state_q;

  logic latch_st = 1'b0;
  logic stuck    = 1'b0;

  int checks   = 0;
  int failures = 0;

  int set_low_cnt   = 0;
  int reset_low_cnt = 0;
  int both_low_cnt  = 0;
  int done_err_cnt  = 0;

  always #5 clk = ~clk;

  sr_latch_driver #(.PULSE_W(2), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_set   (req_set),
    .req_reset (req_reset),
    .set_n     (set_n),
    .reset_n   (reset_n),
    .q         (q),
    .qbar      (qbar),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_q   (state_q)
  );

  // Ideal latch: responds to a low drive immediately.
  always @(set_n or reset_n) begin
    if (!set_n)        latch_st = 1'b1;
    else if (!reset_n) latch_st = 1'b0;
  end

  assign q    = stuck ? 1'b0 : latch_st;
  assign qbar = stuck ? 1'b1 : ~latch_st;

  // Cycle-level monitor of drive activity and exclusivity.
  always @(negedge clk) begin
    if (!set_n)               set_low_cnt   <= set_low_cnt + 1;
    if (!reset_n)             reset_low_cnt <= reset_low_cnt + 1;
    if (!set_n && !reset_n)   both_low_cnt  <= both_low_cnt + 1;
    if (done && err)          done_err_cnt  <= done_err_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_set   = 1'b0;
    req_reset = 1'b0;

    // Reset held for three cycles.
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_set_n",   32'(set_n),   32'd1);
    check("rst_reset_n", 32'(reset_n), 32'd1);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_state_q", 32'(state_q), 32'd0);

    // Set with the ideal latch: set_n low after E0 and E1, done after E3.
    req_set = 1'b1;
    tick();                                   // E0
    req_set = 1'b0;
    check("set_e0_set_n",   32'(set_n),   32'd0);
    check("set_e0_reset_n", 32'(reset_n), 32'd1);
    check("set_e0_busy",    32'(busy),    32'd1);
    tick();                                   // E1
    check("set_e1_set_n",   32'(set_n),   32'd0);
    tick();                                   // E2
    check("set_e2_set_n",   32'(set_n),   32'd1);
    check("set_e2_busy",    32'(busy),    32'd1);
    check("set_e2_done",    32'(done),    32'd0);
    tick();                                   // E3
    check("set_e3_done",    32'(done),    32'd1);
    check("set_e3_busy",    32'(busy),    32'd0);
    check("set_e3_err",     32'(err),     32'd0);
    check("set_e3_state_q", 32'(state_q), 32'd1);
    tick();
    check("set_done_1cyc",  32'(done),    32'd0);
    check("set_low_width",  32'(set_low_cnt),   32'd2);
    check("set_no_rst_low", 32'(reset_low_cnt), 32'd0);

    // Clear after set; a set request while busy is dropped.
    req_reset = 1'b1;
    tick();                                   // E0
    req_reset = 1'b0;
    check("clr_e0_reset_n", 32'(reset_n), 32'd0);
    check("clr_e0_set_n",   32'(set_n),   32'd1);
    req_set = 1'b1;
    tick();                                   // E1 (request ignored)
    req_set = 1'b0;
    check("clr_e1_reset_n", 32'(reset_n), 32'd0);
    check("clr_e1_set_n",   32'(set_n),   32'd1);
    tick();                                   // E2
    check("clr_e2_reset_n", 32'(reset_n), 32'd1);
    tick();                                   // E3
    check("clr_e3_done",    32'(done),    32'd1);
    check("clr_e3_state_q", 32'(state_q), 32'd0);
    tick(); tick(); tick(); tick();
    check("clr_no_2nd_pulse", 32'(set_low_cnt),   32'd2);
    check("clr_rst_width",    32'(reset_low_cnt), 32'd2);
    check("clr_idle_busy",    32'(busy),          32'd0);

    // Both requests in IDLE.
    req_set   = 1'b1;
    req_reset = 1'b1;
    tick();
    req_set   = 1'b0;
    req_reset = 1'b0;
    check("both_err",     32'(err),     32'd1);
    check("both_done",    32'(done),    32'd0);
    check("both_set_n",   32'(set_n),   32'd1);
    check("both_reset_n", 32'(reset_n), 32'd1);
    check("both_busy",    32'(busy),    32'd0);
    check("both_state_q", 32'(state_q), 32'd0);
    tick();
    check("both_err_1cyc", 32'(err),    32'd0);

    // Stuck latch: err after E0 + PULSE_W + TIMEOUT = E17.
    stuck   = 1'b1;
    req_set = 1'b1;
    tick();                                   // E0
    req_set = 1'b0;
    for (int i = 1; i < 17; i++) tick();      // E1 .. E16
    check("stuck_e16_err",  32'(err),     32'd0);
    check("stuck_e16_busy", 32'(busy),    32'd1);
    tick();                                   // E17
    check("stuck_e17_err",     32'(err),     32'd1);
    check("stuck_e17_done",    32'(done),    32'd0);
    check("stuck_e17_busy",    32'(busy),    32'd0);
    check("stuck_e17_state_q", 32'(state_q), 32'd0);
    tick();
    check("stuck_err_1cyc",    32'(err),     32'd0);
    stuck = 1'b0;
    tick(); tick(); tick();

    // Reset during the first set_n low cycle.
    req_set = 1'b1;
    tick();                                   // E0
    req_set = 1'b0;
    check("mid_e0_set_n", 32'(set_n), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_set_n",   32'(set_n),   32'd1);
    check("mid_reset_n", 32'(reset_n), 32'd1);
    check("mid_busy",    32'(busy),    32'd0);
    check("mid_state_q", 32'(state_q), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("mid_no_done", 32'(done), 32'd0);
      check("mid_no_err",  32'(err),  32'd0);
      tick();
    end

    check("never_both_low",  32'(both_low_cnt), 32'd0);
    check("never_done_err",  32'(done_err_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sr_latch_driver.md
# sr_latch_driver

Synchronous driver for an external active-low cross-coupled NAND set/reset latch. It accepts single-cycle set/clear requests, drives a set_n or reset_n pulse of fixed width, and never drives both low. It then watches the latch's q/qbar feedback through a two-flop synchronizer and reports completion, or an error on timeout. It sits between core control logic and any asynchronous SR storage element in the design.

## Interface
- PULSE_W, 2: width of the set_n/reset_n low pulse in clock cycles; legal range ≥1.
- TIMEOUT, 15: maximum cycles spent in WAIT before an error is flagged; legal range ≥1.

- clk  input  1  rising-edge clock, single clock domain.
- reset  input  1  synchronous, active-high reset.
- req_set  input  1  request to set the latch; sampled only in IDLE.
- req_reset  input  1  request to clear the latch; sampled only in IDLE.
- set_n  output  1  active-low set drive to the latch; registered.
- reset_n  output  1  active-low reset drive to the latch; registered.
- q  input  1  latch true output; asynchronous, synchronized internally.
- qbar  input  1  latch complement output; asynchronous, synchronized internally.
- busy  output  1  high while a command is in flight (PULSE or WAIT).
- done  output  1  one-cycle pulse: the latch confirmed the commanded state.
- err  output  1  one-cycle pulse: the request was rejected or the confirmation timed out.
- state_q  output  1  last confirmed latch state (1 = set).

## Operation
- **Synchronizer.** q and qbar each pass through two flops, giving q_s and qbar_s.
- **Match condition.** `match` = (q_s == cmd) && (qbar_s == ~cmd). The forbidden feedback q_s = qbar_s never matches.
- **FSM states.** IDLE, PULSE, WAIT.
- **IDLE**
  - req_set && req_reset: err = 1 next cycle; no pulse is driven; stay in IDLE.
  - req_set only: cmd = 1; go to PULSE; set_n = 0 next cycle.
  - req_reset only: cmd = 0; go to PULSE; reset_n = 0 next cycle.
  - Requests for the state already held are still executed.
- **PULSE**
  - Hold the selected drive low for exactly PULSE_W cycles, counted by a pulse counter.
  - The other drive stays high throughout.
  - On the last pulse cycle, go to WAIT; both drives return high on that edge.
- **WAIT**
  - Both drives are high; a wait counter counts WAIT cycles from 1.
  - match in the current cycle: done = 1, state_q = cmd, go to IDLE.
  - Otherwise, if the wait counter equals TIMEOUT: err = 1, state_q unchanged, go to IDLE.
  - match takes priority over timeout in the same cycle.
- **Ignored requests.** Requests while busy are dropped; there is no queue.
- **Counter widths.** $clog2(PULSE_W+1) and $clog2(TIMEOUT+1) bits. Counters clear on entry to each state and never wrap.

## Timing
- **Reset values.** set_n = 1, reset_n = 1, busy = 0, done = 0, err = 0, state_q = 0, FSM = IDLE, counters = 0, synchronizer flops = 0.
- **Reset mid-operation.** Reset asserted during PULSE or WAIT returns both drives high at the next edge. No done/err is produced for the aborted command.
- **Acceptance.** A request is accepted at edge E0 when the FSM is in IDLE. busy and the low drive appear in the cycle after E0.
- **Pulse window.** The low drive occupies the PULSE_W cycles following E0.
- **Latency.** With an ideal latch that responds immediately, done is high in the cycle following edge E0 + max(PULSE_W, 2) + 1. Defaults: done follows edge E3.
- **Timeout.** Worst case, err is high in the cycle following edge E0 + PULSE_W + TIMEOUT.
- **done/err cycle.** busy = 0 in the same cycle that done or err is high. A request present in that cycle is accepted.
- **Exclusivity.** set_n and reset_n are never both 0 in any cycle. done and err are never both 1.

## Test plan
- **Reset.** Assert reset for 3 cycles, then release → set_n = reset_n = 1, busy = done = err = state_q = 0.
- **Set, defaults.** One-cycle req_set, ideal latch model → set_n low for exactly 2 cycles; done one cycle after edge E3; state_q = 1; reset_n never low.
- **Clear after set.** req_reset → reset_n low for 2 cycles; done pulses; state_q = 0. req_set during busy → ignored, no second pulse.
- **Both requests.** req_set = req_reset = 1 in IDLE → err = 1 for one cycle; both drives stay high; state_q unchanged.
- **Stuck latch.** q held at 0 on a set request → err after PULSE_W + TIMEOUT = 17 cycles from acceptance; state_q remains 0; FSM back in IDLE.
- **Reset mid-pulse.** Assert reset during the first set_n low cycle → set_n = 1 after the next edge; no done/err; outputs at their reset values.
